// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer: runs a 16-bit operation through an external 8-bit ALU
// as two byte slices, low then high, with carry chained between slices.
module ula_op_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_s,
    input  logic        req_m,
    input  logic        req_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_f,
    output logic        rsp_c_out,
    output logic        rsp_overflow,
    output logic        rsp_a_eq_b,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_s,
    output logic        ula_m,
    output logic        ula_c_in,
    input  logic [7:0]  ula_f,
    input  logic        ula_c_out,
    input  logic        ula_overflow,
    input  logic        ula_a_eq_b
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] CNT_LO = 4'(SETTLE_CYCLES - 1);
    // high slice holds one extra cycle, giving 2*SETTLE_CYCLES+1 latency
    localparam logic [3:0] CNT_HI = 4'(SETTLE_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  s_q, s_d;
    logic        m_q, m_d;
    logic        cin_q, cin_d;
    logic        carry_lo_q, carry_lo_d;
    logic        eq_lo_q, eq_lo_d;
    logic [15:0] f_q, f_d;
    logic        c_out_q, c_out_d;
    logic        ov_q, ov_d;
    logic        eq_q, eq_d;

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_f        = f_q;
    assign rsp_c_out    = c_out_q;
    assign rsp_overflow = ov_q;
    assign rsp_a_eq_b   = eq_q;

    // ALU port drive: active slice in LOW/HIGH, zero otherwise
    always_comb begin
        ula_a    = 8'h00;
        ula_b    = 8'h00;
        ula_s    = 4'h0;
        ula_m    = 1'b0;
        ula_c_in = 1'b0;
        if (state_q == LOW) begin
            ula_a    = a_q[7:0];
            ula_b    = b_q[7:0];
            ula_s    = s_q;
            ula_m    = m_q;
            ula_c_in = cin_q;
        end else if (state_q == HIGH) begin
            ula_a    = a_q[15:8];
            ula_b    = b_q[15:8];
            ula_s    = s_q;
            ula_m    = m_q;
            ula_c_in = carry_lo_q;
        end
    end

    // next-state, settle counter and capture logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        s_d        = s_q;
        m_d        = m_q;
        cin_d      = cin_q;
        carry_lo_d = carry_lo_q;
        eq_lo_d    = eq_lo_q;
        f_d        = f_q;
        c_out_d    = c_out_q;
        ov_d       = ov_q;
        eq_d       = eq_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    s_d     = req_s;
                    m_d     = req_m;
                    cin_d   = req_cin;
                    cnt_d   = CNT_LO;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == 4'd0) begin
                    f_d[7:0]   = ula_f;
                    carry_lo_d = ula_c_out;
                    eq_lo_d    = ula_a_eq_b;
                    cnt_d      = CNT_HI;
                    state_d    = HIGH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HIGH: begin
                if (cnt_q == 4'd0) begin
                    f_d[15:8] = ula_f;
                    c_out_d   = ula_c_out;
                    ov_d      = ula_overflow;
                    eq_d      = eq_lo_q & ula_a_eq_b;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // state registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            a_q        <= 16'h0000;
            b_q        <= 16'h0000;
            s_q        <= 4'h0;
            m_q        <= 1'b0;
            cin_q      <= 1'b0;
            carry_lo_q <= 1'b0;
            eq_lo_q    <= 1'b0;
            f_q        <= 16'h0000;
            c_out_q    <= 1'b0;
            ov_q       <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s_q        <= s_d;
            m_q        <= m_d;
            cin_q      <= cin_d;
            carry_lo_q <= carry_lo_d;
            eq_lo_q    <= eq_lo_d;
            f_q        <= f_d;
            c_out_q    <= c_out_d;
            ov_q       <= ov_d;
            eq_q       <= eq_d;
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Testbench for ula_op_sequencer with a behavioural 8-bit ALU stand-in
// and a whole-word 16-bit reference model.
module tb_ula_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // byte ALU: m=0 arithmetic (s=1000 subtract, else add), m=1 logic
    function automatic logic [10:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s, input logic m,
                                         input logic cin);
        logic [8:0] sum;
        logic [7:0] y;
        logic ov;
        if (m) begin
            case (s[1:0])
                2'd0: y = a & b;
                2'd1: y = a | b;
                2'd2: y = a ^ b;
                default: y = ~a;
            endcase
            return {y, 1'b0, 1'b0, a == b};
        end
        y   = (s == 4'b1000) ? ~b : b;
        sum = {1'b0, a} + {1'b0, y} + {8'd0, cin};
        ov  = (a[7] == y[7]) && (sum[7] != a[7]);
        return {sum[7:0], sum[8], ov, a == b};
    endfunction

    // whole-word reference: {f, c_out, overflow, a_eq_b}
    function automatic logic [18:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s, input logic m,
                                          input logic cin);
        int unsigned x, y, sum;
        logic [15:0] f;
        logic ov;
        if (m) begin
            case (s[1:0])
                2'd0: f = a & b;
                2'd1: f = a | b;
                2'd2: f = a ^ b;
                default: f = ~a;
            endcase
            return {f, 1'b0, 1'b0, a == b};
        end
        x   = a;
        y   = (s == 4'b1000) ? (b ^ 16'hFFFF) : b;
        sum = x + y + cin;
        f   = sum[15:0];
        ov  = (a[15] == y[15]) && (f[15] != a[15]);
        return {f, sum[16], ov, a == b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- DUT with SETTLE_CYCLES=1 ----------------
    logic        rst_n;
    logic        req_valid, req_ready, req_m, req_cin;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_s;
    logic        rsp_valid, rsp_ready, rsp_c_out, rsp_overflow, rsp_a_eq_b;
    logic [15:0] rsp_f;
    logic [7:0]  ula_a, ula_b, ula_f;
    logic [3:0]  ula_s;
    logic        ula_m, ula_c_in, ula_c_out, ula_overflow, ula_a_eq_b;

    assign {ula_f, ula_c_out, ula_overflow, ula_a_eq_b} =
        alu8(ula_a, ula_b, ula_s, ula_m, ula_c_in);

    ula_op_sequencer #(.SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s),
        .req_m(req_m), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_c_out(rsp_c_out),
        .rsp_overflow(rsp_overflow), .rsp_a_eq_b(rsp_a_eq_b),
        .ula_a(ula_a), .ula_b(ula_b), .ula_s(ula_s),
        .ula_m(ula_m), .ula_c_in(ula_c_in),
        .ula_f(ula_f), .ula_c_out(ula_c_out),
        .ula_overflow(ula_overflow), .ula_a_eq_b(ula_a_eq_b)
    );

    // ---------------- DUT with SETTLE_CYCLES=3 ----------------
    logic        req_valid3, req_ready3, req_m3, req_cin3;
    logic [15:0] req_a3, req_b3;
    logic [3:0]  req_s3;
    logic        rsp_valid3, rsp_ready3, rsp_c_out3, rsp_overflow3, rsp_a_eq_b3;
    logic [15:0] rsp_f3;
    logic [7:0]  ula_a3, ula_b3, ula_f3;
    logic [3:0]  ula_s3;
    logic        ula_m3, ula_c_in3, ula_c_out3, ula_overflow3, ula_a_eq_b3;

    assign {ula_f3, ula_c_out3, ula_overflow3, ula_a_eq_b3} =
        alu8(ula_a3, ula_b3, ula_s3, ula_m3, ula_c_in3);

    ula_op_sequencer #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .req_s(req_s3),
        .req_m(req_m3), .req_cin(req_cin3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_f(rsp_f3), .rsp_c_out(rsp_c_out3),
        .rsp_overflow(rsp_overflow3), .rsp_a_eq_b(rsp_a_eq_b3),
        .ula_a(ula_a3), .ula_b(ula_b3), .ula_s(ula_s3),
        .ula_m(ula_m3), .ula_c_in(ula_c_in3),
        .ula_f(ula_f3), .ula_c_out(ula_c_out3),
        .ula_overflow(ula_overflow3), .ula_a_eq_b(ula_a_eq_b3)
    );

    // one full operation on dut, with optional back-pressure in DONE
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic m, input logic cin,
                          input int hold);
        logic [18:0] exp;
        logic [18:0] held;
        int lat;
        int w;
        exp = ref16(a, b, s, m, cin);
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 16'($urandom);
        req_s = 4'($urandom); req_m = 1'($urandom); req_cin = 1'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            req_valid = 1'($urandom);
            req_a = 16'($urandom); req_b = 16'($urandom);
        end
        req_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        chk({tag, ".result"}, 32'({rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b}), 32'(exp));
        held = {rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'({rsp_valid, req_ready}), 32'b10);
            chk({tag, ".hold_data"}, 32'({rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b}),
                32'(held));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, ".idle"}, 32'({rsp_valid, req_ready, ula_a, ula_b}), 32'h1_0000);
    endtask

    initial begin
        int lat;
        logic [7:0] trace[$];
        logic [3:0] rs;
        logic rm;
        rst_n = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0; req_cin = 1'b0;
        rsp_ready = 1'b0;
        req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_s3 = '0; req_m3 = 1'b0;
        req_cin3 = 1'b0; rsp_ready3 = 1'b1;
        #12;
        chk("reset_out", 32'({rsp_valid, rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b}), 32'd0);
        chk("reset_ula", 32'({ula_a, ula_b, ula_s, ula_m, ula_c_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        run_op("add_carry", 16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0, 0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 4'b0101, 1'b0, 1'b0, 0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 4'b0101, 1'b0, 1'b0, 0);
        run_op("sub_eq", 16'h1234, 16'h1234, 4'b1000, 1'b0, 1'b1, 0);
        run_op("sub_ne_lo", 16'h1234, 16'h1235, 4'b1000, 1'b0, 1'b1, 0);
        run_op("sub_ne_hi", 16'h1234, 16'h9234, 4'b1000, 1'b0, 1'b1, 0);
        run_op("backpressure", 16'hA55A, 16'h0F0F, 4'b0101, 1'b0, 1'b1, 5);

        // reset asserted while the high slice is in flight
        @(negedge clk);
        req_valid = 1'b1;
        req_a = 16'h1234; req_b = 16'h1111; req_s = 4'b0101; req_m = 1'b0; req_cin = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 32'({rsp_valid, rsp_f, rsp_c_out, rsp_overflow, rsp_a_eq_b}),
            32'd0);
        chk("rst_mid_ula", 32'({ula_a, ula_b, ula_s, ula_m, ula_c_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) lat++;
        end
        chk("rst_mid_no_rsp", 32'(lat), 32'd0);
        run_op("after_reset", 16'h00FF, 16'h0001, 4'b0101, 1'b0, 1'b0, 0);

        // randomized operations against the whole-word model
        for (int n = 0; n < 30; n++) begin
            rm = 1'($urandom);
            rs = rm ? 4'($urandom_range(0, 3)) : (($urandom & 1) != 0 ? 4'b1000 : 4'b0101);
            run_op($sformatf("rand%0d", n), 16'($urandom), 16'($urandom), rs, rm,
                   1'($urandom), int'($urandom_range(0, 2)));
        end

        // SETTLE_CYCLES=3: slice hold times and 7-edge latency
        @(negedge clk);
        req_valid3 = 1'b1;
        req_a3 = 16'h00FF; req_b3 = 16'h0001; req_s3 = 4'b0101; req_m3 = 1'b0; req_cin3 = 1'b0;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        trace.push_back(ula_a3);
        lat = 0;
        while (!rsp_valid3 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
            if (!rsp_valid3) trace.push_back(ula_a3);
        end
        chk("s3.latency", 32'(lat), 32'd7);
        chk("s3.result", 32'({rsp_f3, rsp_c_out3, rsp_overflow3, rsp_a_eq_b3}),
            32'({16'h0100, 3'b000}));
        chk("s3.trace_len", 32'(trace.size()), 32'd7);
        for (int i = 0; i < trace.size(); i++) begin
            chk($sformatf("s3.ula_a%0d", i), 32'(trace[i]), (i < 3) ? 32'hFF : 32'h00);
        end
        @(posedge clk);
        #1;
        chk("s3.idle", 32'({rsp_valid3, req_ready3}), 32'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
